serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor. A single 1-bit full-subtractor cell is sequenced LSB-first over a WIDTH-bit operand pair, and the borrow is carried between bit-times in a register. The block sits between a requesting controller and the full-subtractor datapath. It owns operand capture, bit sequencing, borrow chaining, result commit and the start/busy/done handshake. One bit is processed per clock, trading latency for area.

---
 rtl/serial_subtractor_ctrl_if.sv | 24 ++
 rtl/serial_subtractor_ctrl.sv | 98 +++++++++
 tb/tb_serial_subtractor_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle between a controller and the bit-serial subtractor.
// The master side issues operands and start; the slave side reports progress and the result.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrow;

    modport master (
        output start, a, b, bin,
        input  busy, done, difference, borrow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, difference, borrow
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell is walked LSB-first over the operands,
// with the borrow chained between bit-times in a register; one bit per clock.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] wr;
    logic [WIDTH-1:0] wr_next;
    logic [WIDTH-1:0] d_msb;
    logic [WIDTH-1:0] difference;
    logic             br;
    logic             borrow;
    logic             d;
    logic             bo;
    logic             last_bit;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The new difference bit enters at the MSB so that bit 0 ends up in wr[0] after WIDTH shifts.
    always_comb begin
        state_next         = state;
        d                  = sa[0] ^ sb[0] ^ br;
        bo                 = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        last_bit           = (cnt == CW'(WIDTH - 1));
        d_msb              = '0;
        d_msb[WIDTH-1]     = d;
        wr_next            = (wr >> 1) | d_msb;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            wr         <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            difference <= '0;
            borrow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        br  <= bus.bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    wr  <= wr_next;
                    br  <= bo;
                    cnt <= cnt + 1'b1;
                    // Result becomes visible only once every bit has been produced.
                    if (last_bit) begin
                        difference <= wr_next;
                        borrow     <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.difference = difference;
    assign bus.borrow     = borrow;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: an 8-bit and a 1-bit instance are compared
// against an arithmetic model of (a - b - bin) and the start/busy/done timing rules.
module tb_serial_subtractor_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] lastDiff8;
    logic        lastBorrow8;
    logic [31:0] lastDiff1;
    logic        lastBorrow1;
    logic [31:0] arrA [0:40];
    logic [31:0] arrB [0:40];
    logic        arrBin [0:40];

    serial_subtractor_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelDiff(input int w, input logic [31:0] av, input logic [31:0] bv,
                                              input logic binv);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        return ((av & mask) - (bv & mask) - {31'b0, binv}) & mask;
    endfunction

    function automatic logic modelBorrow(input int w, input logic [31:0] av, input logic [31:0] bv,
                                         input logic binv);
        logic [32:0] mask;
        mask = (33'h1 << w) - 33'h1;
        return ({1'b0, av} & mask) < (({1'b0, bv} & mask) + {32'b0, binv});
    endfunction

    // One complete transaction on the chosen instance, checking handshake timing and result.
    task automatic applyStimulus(input int w, input logic [31:0] av, input logic [31:0] bv, input logic binv);
        logic [31:0] expD;
        logic        expB;
        logic [31:0] prevD;
        logic        seen;
        logic        obsDone;
        logic        obsBusy;
        logic [31:0] obsDiff;
        logic        obsBorrow;
        int          busyCnt;
        expD  = modelDiff(w, av, bv, binv);
        expB  = modelBorrow(w, av, bv, binv);
        prevD = (w == 1) ? lastDiff1 : lastDiff8;
        @(negedge clk);
        if (w == 1) begin
            bus1.start = 1'b1; bus1.a = av[0]; bus1.b = bv[0]; bus1.bin = binv;
        end else begin
            bus8.start = 1'b1; bus8.a = av[7:0]; bus8.b = bv[7:0]; bus8.bin = binv;
        end
        @(negedge clk);
        bus1.start = 1'b0;
        bus8.start = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        busyCnt = 0;
        seen    = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            obsDone = (w == 1) ? bus1.done : bus8.done;
            obsBusy = (w == 1) ? bus1.busy : bus8.busy;
            obsDiff = (w == 1) ? 32'(bus1.difference) : 32'(bus8.difference);
            if (obsDone) begin
                seen = 1'b1;
            end else begin
                if (obsBusy) busyCnt++;
                if (k == 0) checkOutput("holdPrevDiff", obsDiff, prevD);
                @(negedge clk);
            end
        end
        checkOutput("doneSeen", {31'b0, seen}, 32'h1);
        checkOutput("busyLen", busyCnt, w);
        obsBusy   = (w == 1) ? bus1.busy : bus8.busy;
        obsDiff   = (w == 1) ? 32'(bus1.difference) : 32'(bus8.difference);
        obsBorrow = (w == 1) ? bus1.borrow : bus8.borrow;
        checkOutput("busyAtDone", {31'b0, obsBusy}, 32'h0);
        checkOutput("difference", obsDiff, expD);
        checkOutput("borrow", {31'b0, obsBorrow}, {31'b0, expB});
        @(negedge clk);
        obsDone = (w == 1) ? bus1.done : bus8.done;
        checkOutput("donePulseLen", {31'b0, obsDone}, 32'h0);
        if (w == 1) begin
            lastDiff1 = expD; lastBorrow1 = expB;
        end else begin
            lastDiff8 = expD; lastBorrow8 = expB;
        end
    endtask

    initial begin
        logic [32:0] expBusyCycle;
        int          k;
        int          doneCount;
        checks = 0;
        errors = 0;
        lastDiff8 = '0; lastBorrow8 = 1'b0;
        lastDiff1 = '0; lastBorrow1 = 1'b0;
        rst = 1'b1;
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h11; bus8.bin = 1'b1;
        bus1.start = 1'b1; bus1.a = 1'b1;  bus1.b = 1'b0;  bus1.bin = 1'b0;

        // Reset held with start high must not accept anything.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstBusy", {31'b0, bus8.busy}, 32'h0);
        checkOutput("rstDone", {31'b0, bus8.done}, 32'h0);
        checkOutput("rstDiff", 32'(bus8.difference), 32'h0);
        checkOutput("rstBorrow", {31'b0, bus8.borrow}, 32'h0);
        checkOutput("rstBusy1", {31'b0, bus1.busy}, 32'h0);
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8, 32'h5A, 32'h23, 1'b0);
        applyStimulus(8, 32'h00, 32'h01, 1'b0);
        applyStimulus(8, 32'h00, 32'h00, 1'b1);
        applyStimulus(8, 32'h80, 32'h7F, 1'b1);
        applyStimulus(8, 32'hFF, 32'hFF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8, $urandom, $urandom, 1'($urandom));
        end

        // Start held high with operands changing every cycle: acceptances land every WIDTH+2 edges.
        doneCount = 0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                k = c - 1;
                expBusyCycle = (k <= 38 && (k % 10) < 8) ? 33'h1 : 33'h0;
                checkOutput("b2bBusy", {31'b0, bus8.busy}, expBusyCycle[31:0]);
                checkOutput("b2bDone", {31'b0, bus8.done}, ((k % 10) == 8) ? 32'h1 : 32'h0);
                if ((k % 10) == 8) begin
                    lastDiff8   = modelDiff(8, arrA[k-8], arrB[k-8], arrBin[k-8]);
                    lastBorrow8 = modelBorrow(8, arrA[k-8], arrB[k-8], arrBin[k-8]);
                    doneCount++;
                end
                checkOutput("b2bDiff", 32'(bus8.difference), lastDiff8);
                checkOutput("b2bBorrow", {31'b0, bus8.borrow}, {31'b0, lastBorrow8});
            end
            arrA[c]    = 32'($urandom_range(255));
            arrB[c]    = 32'($urandom_range(255));
            arrBin[c]  = 1'($urandom);
            bus8.a     = arrA[c][7:0];
            bus8.b     = arrB[c][7:0];
            bus8.bin   = arrBin[c];
            bus8.start = (c <= 30);
        end
        bus8.start = 1'b0;
        checkOutput("b2bDoneCount", doneCount, 4);

        // Reset on the 4th RUN edge abandons the operation.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h5E; bus8.bin = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstBusy", {31'b0, bus8.busy}, 32'h0);
        checkOutput("midRstDone", {31'b0, bus8.done}, 32'h0);
        checkOutput("midRstDiff", 32'(bus8.difference), 32'h0);
        checkOutput("midRstBorrow", {31'b0, bus8.borrow}, 32'h0);
        rst = 1'b0;
        lastDiff8 = '0; lastBorrow8 = 1'b0;
        lastDiff1 = '0; lastBorrow1 = 1'b0;
        doneCount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus8.done) doneCount++;
        end
        checkOutput("midRstNoDone", doneCount, 0);
        applyStimulus(8, 32'h10, 32'h01, 1'b0);

        // Exhaustive single-bit instance against the full-subtractor truth table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 32'((i >> 2) & 1), 32'((i >> 1) & 1), 1'(i & 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
